// File: rtl/mmio_result_sink.sv
// mmio_result_sink: memory-mapped responder on the RISC-V core's store bus.
// It decodes stores into a result/scratch region and raises sticky done/pass/fail flags.
// Scratch stores are logged into a drainable FIFO.
// An optional 32-bit execution signature covers Instr/PC/store data.
// Optional feature macro: SIG_HASH_EN (when undefined, sig is tied to 0).
// Ports:
//   clk, reset                  : clock (rising edge), async active-high reset
//   MemWrite, DataAdr, WriteData: core store interface
//   Instr, PC                   : core state folded into the signature
//   done, pass, fail            : sticky run-status flags
//   sig                         : execution signature
//   log_valid, log_data         : scratch FIFO head
//   log_ready                   : consumer pops the head
//   log_ovf                     : dropped scratch stores, saturating at 255
module mmio_result_sink #(
  parameter logic [31:0] RESULT_ADR  = 32'h64,
  parameter logic [31:0] SCRATCH_ADR = 32'h60,
  parameter logic [31:0] PASS_VALUE  = 32'd25,
  parameter int unsigned LOG_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [31:0] Instr,
  input  logic [31:0] PC,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic [31:0] sig,
  output logic        log_valid,
  output logic [31:0] log_data,
  input  logic        log_ready,
  output logic [7:0]  log_ovf
);

  localparam int unsigned AW = $clog2(LOG_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

  state_t state;
  state_t state_next;
  logic   run;

  assign run = (state == ST_RUN);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_next;
  end

  // Store decode; PASS and FAIL are terminal
  always_comb begin
    state_next = state;
    if (run && MemWrite) begin
      if (DataAdr == RESULT_ADR)
        state_next = (WriteData == PASS_VALUE) ? ST_PASS : ST_FAIL;
      else if (DataAdr != SCRATCH_ADR)
        state_next = ST_FAIL;
    end
  end

  // Moore flag outputs, decoded from the registered state only
  always_comb begin
    done = 1'b0;
    pass = 1'b0;
    fail = 1'b0;
    case (state)
      ST_PASS: begin done = 1'b1; pass = 1'b1; end
      ST_FAIL: begin done = 1'b1; fail = 1'b1; end
      default: ;
    endcase
  end

  // Scratch log FIFO; the extra pointer bit distinguishes full from empty
  logic [31:0]   mem [LOG_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          empty;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;

  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push_req = run && MemWrite && (DataAdr == SCRATCH_ADR);
  assign pop      = !empty && log_ready;
  // A same-cycle pop frees the slot, so a push into a full FIFO is still taken
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem  <= '{default: '0};
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) begin
        mem[wptr[AW-1:0]] <= WriteData;
        wptr              <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
    end
  end

  // Dropped-push counter, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      log_ovf <= 8'h00;
    else if (push_req && !push && (log_ovf != 8'hFF))
      log_ovf <= log_ovf + 8'd1;
  end

  assign log_valid = !empty;
  assign log_data  = mem[rptr[AW-1:0]];

`ifdef SIG_HASH_EN
  logic [31:0] sig_q;
  logic [31:0] sig_t;

  always_comb sig_t = sig_q ^ Instr ^ PC ^ (MemWrite ? WriteData : 32'h0);

  // LFSR-style shift with feedback; freezes once the run has terminated
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    sig_q <= 32'h0;
    else if (run) sig_q <= {sig_t[30:0], sig_t[9] ^ sig_t[29] ^ sig_t[30] ^ sig_t[31]};
  end

  assign sig = sig_q;
`else
  logic unused_sig_inputs;
  assign unused_sig_inputs = ^{Instr, PC};
  assign sig = 32'h0;
`endif

endmodule

// File: tb/tb_mmio_result_sink.sv
// Self-checking bench for mmio_result_sink: flags, signature, scratch FIFO
// scoreboard, overflow handling and asynchronous reset.
module tb_mmio_result_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic        done;
  logic        pass;
  logic        fail;
  logic [31:0] sig;
  logic        log_valid;
  logic [31:0] log_data;
  logic        log_ready;
  logic [7:0]  log_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];

  mmio_result_sink dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .Instr     (Instr),
    .PC        (PC),
    .done      (done),
    .pass      (pass),
    .fail      (fail),
    .sig       (sig),
    .log_valid (log_valid),
    .log_data  (log_data),
    .log_ready (log_ready),
    .log_ovf   (log_ovf)
  );

  always #5 clk = ~clk;

  // Reference signature model, following the spec's update rule
  logic [31:0] m_sig;
  logic        m_run;
  logic [31:0] m_t;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sig <= 32'h0;
      m_run <= 1'b1;
    end else if (m_run) begin
      m_t = m_sig ^ Instr ^ PC ^ (MemWrite ? WriteData : 32'h0);
      m_sig <= {m_t[30:0], m_t[9] ^ m_t[29] ^ m_t[30] ^ m_t[31]};
      if (MemWrite && (DataAdr != 32'h60)) m_run <= 1'b0;
    end
  end

  function automatic logic [31:0] exp_sig();
`ifdef SIG_HASH_EN
    return m_sig;
`else
    return 32'h0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #3;
    reset = 1'b0;
    exp_q.delete();
  endtask

  // One store, asserted across a single rising edge; scratch stores go to the scoreboard
  task automatic store(input logic [31:0] adr, input logic [31:0] data, input bit expect_push);
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = adr;
    WriteData = data;
    Instr     = 32'h0000_0023 ^ (data << 20);
    PC        = PC + 32'd4;
    if (expect_push) exp_q.push_back(data);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
  endtask

  // Pop every scoreboard entry, comparing FIFO head data in order
  task automatic drain(input string name);
    logic [31:0] e;
    int          n;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n = 0;
      @(negedge clk);
      while (!log_valid && n < 5) begin
        @(negedge clk);
        n++;
      end
      n_checks++;
      if (!log_valid) begin
        $display("FAIL %s: log_valid stuck low, expected data %h", name, e);
      end else if (log_data !== e) begin
        $display("FAIL %s: log_data got %h want %h", name, log_data, e);
      end else n_pass++;
      log_ready = 1'b1;
      @(posedge clk);
      #1;
      log_ready = 1'b0;
    end
    n_checks++;
    if (log_valid !== 1'b0) $display("FAIL %s_empty: log_valid got %b want 0", name, log_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemWrite = 1'b0; DataAdr = 32'h0; WriteData = 32'h0;
    Instr = 32'h0; PC = 32'h0; log_ready = 1'b0;
    #22;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({done, pass, fail, log_valid} !== 4'b0000)
      $display("FAIL reset_flags: done/pass/fail/valid got %b want 0000", {done, pass, fail, log_valid});
    else n_pass++;
    n_checks++;
    if ({sig, log_data, log_ovf} !== 72'h0)
      $display("FAIL reset_data: sig %h log_data %h ovf %h want all 0", sig, log_data, log_ovf);
    else n_pass++;
  endtask

  task automatic test_sig_step();
    logic [31:0] e;
    @(negedge clk);
    Instr = 32'h13; PC = 32'h0;
    @(posedge clk);
    #1;
`ifdef SIG_HASH_EN
    e = 32'h26;
`else
    e = 32'h0;
`endif
    n_checks++;
    if (sig !== e) $display("FAIL sig_step: sig got %h want %h", sig, e);
    else n_pass++;
  endtask

  task automatic test_pass_run();
    do_reset();
    store(32'h60, 32'd7, 1'b1);
    n_checks++;
    if (done !== 1'b0) $display("FAIL pass_run_mid: done got %b want 0", done);
    else n_pass++;
    store(32'h64, 32'd25, 1'b0);
    n_checks++;
    if ({done, pass, fail} !== 3'b110)
      $display("FAIL pass_run_flags: done/pass/fail got %b want 110", {done, pass, fail});
    else n_pass++;
    n_checks++;
    if (sig !== exp_sig()) $display("FAIL pass_run_sig: sig got %h want %h", sig, exp_sig());
    else n_pass++;
    drain("pass_run_fifo");
    store(32'h70, 32'd9, 1'b0);
    n_checks++;
    if ({done, pass, fail, log_valid} !== 4'b1100)
      $display("FAIL ignored_store: done/pass/fail/valid got %b want 1100", {done, pass, fail, log_valid});
    else n_pass++;
    n_checks++;
    if (sig !== exp_sig()) $display("FAIL ignored_sig: sig got %h want %h", sig, exp_sig());
    else n_pass++;
  endtask

  task automatic test_fail_result();
    do_reset();
    store(32'h64, 32'd26, 1'b0);
    n_checks++;
    if ({done, pass, fail} !== 3'b101)
      $display("FAIL fail_result: done/pass/fail got %b want 101", {done, pass, fail});
    else n_pass++;
  endtask

  task automatic test_fail_addr();
    do_reset();
    store(32'h00, 32'd25, 1'b0);
    n_checks++;
    if ({done, pass, fail} !== 3'b101)
      $display("FAIL fail_addr: done/pass/fail got %b want 101", {done, pass, fail});
    else n_pass++;
    n_checks++;
    if (log_valid !== 1'b0) $display("FAIL fail_addr_nopush: log_valid got %b want 0", log_valid);
    else n_pass++;
  endtask

  task automatic test_fifo_overflow();
    do_reset();
    log_ready = 1'b0;
    for (int i = 1; i <= 9; i++) store(32'h60, 32'(i), i <= 8);
    n_checks++;
    if (log_ovf !== 8'd1) $display("FAIL overflow: log_ovf got %0d want 1", log_ovf);
    else n_pass++;
    // Full FIFO: push 10 and pop the head on the same edge
    @(negedge clk);
    n_checks++;
    if (log_data !== exp_q[0]) $display("FAIL full_head: log_data got %h want %h", log_data, exp_q[0]);
    else n_pass++;
    void'(exp_q.pop_front());
    MemWrite = 1'b1; DataAdr = 32'h60; WriteData = 32'd10; log_ready = 1'b1;
    exp_q.push_back(32'd10);
    @(posedge clk);
    #1;
    MemWrite = 1'b0; log_ready = 1'b0;
    n_checks++;
    if (log_ovf !== 8'd1) $display("FAIL push_pop_full: log_ovf got %0d want 1", log_ovf);
    else n_pass++;
    n_checks++;
    if (done !== 1'b0) $display("FAIL overflow_run: done got %b want 0", done);
    else n_pass++;
    drain("overflow_drain");
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    for (int i = 0; i < 3; i++) store(32'h60, 32'hA5A5_0000 + 32'(i), 1'b1);
    n_checks++;
    if (log_valid !== 1'b1) $display("FAIL mid_reset_pre: log_valid got %b want 1", log_valid);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({log_valid, done} !== 2'b00 || sig !== 32'h0 || log_ovf !== 8'h0 || log_data !== 32'h0)
      $display("FAIL mid_reset: valid %b done %b sig %h ovf %h data %h want all 0",
               log_valid, done, sig, log_ovf, log_data);
    else n_pass++;
    #2;
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_sig_step();
    test_pass_run();
    test_fail_result();
    test_fail_addr();
    test_fifo_overflow();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mmio_result_sink.md
# mmio_result_sink

- Synthesizable memory-mapped responder on the multicycle RISC-V core's store interface (`MemWrite`, `DataAdr`, `WriteData`).
- Decodes stores into a small result/scratch region and raises sticky pass/fail/done flags.
- Logs scratch stores into a drainable FIFO and accumulates a 32-bit execution signature over `Instr`/`PC`/store data.
- Lets a self-checking run complete in hardware, e.g. on an FPGA, without a simulator-side checker.

## Interface
Parameters:
- `RESULT_ADR`, 32'h64: address whose store ends the run.
- `SCRATCH_ADR`, 32'h60: address whose stores are legal and logged.
- `PASS_VALUE`, 32'd25: value at `RESULT_ADR` meaning pass.
- `LOG_DEPTH`, 8: scratch FIFO entries, power of two, ≥2.

Ports:
- `clk` in 1: clock, rising-edge active.
- `reset` in 1: asynchronous, active-high.
- `MemWrite` in 1: core store strobe, sampled each rising edge.
- `DataAdr` in 32: store address.
- `WriteData` in 32: store data.
- `Instr` in 32: core's current instruction register.
- `PC` in 32: core's current PC.
- `done` out 1: sticky, run finished.
- `pass` out 1: sticky, finished with correct result.
- `fail` out 1: sticky, illegal store or wrong result.
- `sig` out 32: execution signature.
- `log_valid` out 1: FIFO head valid.
- `log_data` out 32: FIFO head data.
- `log_ready` in 1: consumer accepts head.
- `log_ovf` out 8: dropped-scratch-store count, saturating at 255.

## Operation
- **States:** RUN → PASS or FAIL. PASS and FAIL are terminal until `reset`.
- **Outputs per state:** `done`=0 in RUN, 1 otherwise. `pass`=1 only in PASS. `fail`=1 only in FAIL.
- **Store decode in RUN**, on each edge with `MemWrite`=1:
  - `DataAdr`==`RESULT_ADR`, `WriteData`==`PASS_VALUE` → PASS.
  - `DataAdr`==`RESULT_ADR`, other data → FAIL.
  - `DataAdr`==`SCRATCH_ADR` → push `WriteData` into FIFO; stay in RUN.
  - Any other address → FAIL.
- **Stores outside RUN:** ignored (no push, no signature update).
- **Comparisons:** full 32-bit equality; X/Z never appears on the core bus.
- **Signature:** each edge in RUN:
  - t = sig ^ Instr ^ PC ^ (`MemWrite` ? `WriteData` : 0).
  - sig ← {t[30:0], t[9]^t[29]^t[30]^t[31]}.
  - The terminating store's cycle is included; sig freezes afterwards.
- **FIFO:**
  - Push is dropped when full and pop does not fire; `log_ovf` increments instead.
  - Pop when `log_valid` && `log_ready`.
  - Pointers are log2(`LOG_DEPTH`)+1 bits and wrap naturally. Full = MSBs differ and low bits equal.
  - FIFO keeps draining after `done`.

## Timing
- **Reset values:** state RUN; `done`/`pass`/`fail` 0; `sig` 0; `log_valid` 0; `log_data` 0; `log_ovf` 0; FIFO pointers 0.
- **Mid-operation reset:** async reset at any time clears everything immediately, including FIFO contents.
- **Flag latency:** flags assert one edge after the deciding store (registered state); there is no combinational path from inputs to outputs.
- **FIFO latency:** push at edge N → `log_valid`=1, `log_data` valid after edge N when the FIFO was empty. There is no fall-through.
- **Full + push + pop in the same cycle:** pop frees a slot and the push is accepted. No overflow count; occupancy unchanged.
- **Empty + pop:** a pop with `log_valid`=0 is a no-op.
- **Data stability:** `log_data` holds while `log_valid`=1 and `log_ready`=0.
- **Throughput:** one store per cycle.

## Configuration
- **`SIG_HASH_EN` defined:** signature logic as above.
- **`SIG_HASH_EN` undefined:** signature register and XOR/feedback logic are omitted; `sig` is tied to 32'h0. All other behaviour is unchanged.

## Test plan
- **Reset state:** `reset` held 22 ns, no stores → all outputs 0 and `log_valid`=0 after release.
- **Signature step:** one RUN edge with `Instr`=32'h13, `PC`=0, `MemWrite`=0 → `sig`=32'h26. Without `SIG_HASH_EN`, `sig` stays 0.
- **Pass run:**
  - Stimulus: store 7 to 0x60, then 25 to 0x64.
  - Flags: `done`=`pass`=1 one edge after the second store; `fail`=0.
  - FIFO: pops 7, then `log_valid`=0.
  - Ignored store: later store 9 to 0x70 → flags and `sig` unchanged.
- **Fail cases:**
  - Store 26 to 0x64 → `done`=`fail`=1, `pass`=0.
  - Separate run: store to 0x00 → `fail`=1.
- **FIFO full/overflow:**
  - Stimulus: `log_ready`=0, 9 stores of 1..9 to 0x60 with `LOG_DEPTH`=8.
  - Overflow: `log_ovf`=1.
  - Same-cycle push/pop: store 10 with `log_ready`=1 on the same edge → no further overflow.
  - Drain order: 2..8, then 10.
- **Reset mid-run:** assert `reset` with 3 FIFO entries and nonzero `sig` → `log_valid`, `sig`, `log_ovf` are 0 immediately, before the next clock edge.
